// File: rtl/uart_rx_edge_bit_sampler_if.sv
// Signal bundle between the RX controller FSM (master) and the edge/bit sampler (slave).
interface uart_rx_edge_bit_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  rx_in;
  logic                  enable;
  logic                  data_sample_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;

  modport master (
    output rx_in,
    output enable,
    output data_sample_en,
    output prescale,
    input  edge_cnt,
    input  bit_cnt,
    input  sampled_bit,
    input  sample_valid
  );

  modport slave (
    input  rx_in,
    input  enable,
    input  data_sample_en,
    input  prescale,
    output edge_cnt,
    output bit_cnt,
    output sampled_bit,
    output sample_valid
  );
endinterface

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX oversampling stage: edge/bit counters for the RX FSM plus a
// 3-point majority-voted bit sample with a one-cycle valid strobe.
module uart_rx_edge_bit_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input logic                      clk,
  input logic                      rst,
  uart_rx_edge_bit_sampler_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_DEF = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] PRESCALE_MIN = PRESCALE_W'(6);
  localparam logic [PRESCALE_W-1:0] ONE_P        = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  BIT_MAX      = '1;

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_valid_q, sample_valid_d;

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] pt_lo;
  logic [PRESCALE_W-1:0] pt_hi;
  logic [PRESCALE_W-1:0] edge_last;
  logic                  sample_en;
  logic                  maj;

  always_comb begin
    half      = prescale_q >> 1;
    pt_lo     = half - ONE_P;
    pt_hi     = half + ONE_P;
    edge_last = prescale_q - ONE_P;
    sample_en = bus.enable && bus.data_sample_en;
    maj       = (s0_q & s1_q) | (s0_q & bus.rx_in) | (s1_q & bus.rx_in);

    prescale_d     = prescale_q;
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    s0_d           = s0_q;
    s1_d           = s1_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;

    // Ratio is only tracked while idle so it stays fixed across a frame.
    if (!bus.enable) begin
      prescale_d = (bus.prescale < PRESCALE_MIN) ? PRESCALE_DEF : bus.prescale;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (edge_cnt_q == edge_last) begin
      edge_cnt_d = '0;
      if (bit_cnt_q != BIT_MAX) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else begin
      edge_cnt_d = edge_cnt_q + ONE_P;
    end

    if (sample_en) begin
      if (edge_cnt_q == pt_lo) begin
        s0_d = bus.rx_in;
      end
      if (edge_cnt_q == half) begin
        s1_d = bus.rx_in;
      end
      if (edge_cnt_q == pt_hi) begin
        sampled_bit_d  = maj;
        sample_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q     <= PRESCALE_DEF;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      s0_q           <= 1'b1;
      s1_q           <= 1'b1;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
    end else begin
      prescale_q     <= prescale_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bus.edge_cnt     = edge_cnt_q;
  assign bus.bit_cnt      = bit_cnt_q;
  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Directed bench for uart_rx_edge_bit_sampler: reset, counting, majority vote,
// prescale freeze, illegal prescale/saturation and mid-frame reset.
module tb_uart_rx_edge_bit_sampler;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cyc;
  logic exp_sb;

  uart_rx_edge_bit_sampler_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) bus ();

  uart_rx_edge_bit_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input int b, input logic sb, input logic sv);
    chk({tag, ".edge_cnt"}, 32'(bus.edge_cnt), 32'(e));
    chk({tag, ".bit_cnt"}, 32'(bus.bit_cnt), 32'(b));
    chk({tag, ".sampled_bit"}, 32'(bus.sampled_bit), 32'(sb));
    chk({tag, ".sample_valid"}, 32'(bus.sample_valid), 32'(sv));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Majority-vote patterns: rx_in at edges 7/8/9 and elsewhere, per bit (prescale 16).
  function automatic logic rx_pat(input int b, input int e);
    logic v7, v8, v9, oth;
    case (b)
      0:       begin v7 = 1'b1; v8 = 1'b0; v9 = 1'b0; oth = 1'b1; end
      1:       begin v7 = 1'b0; v8 = 1'b1; v9 = 1'b1; oth = 1'b0; end
      2:       begin v7 = 1'b0; v8 = 1'b0; v9 = 1'b1; oth = 1'b1; end
      3:       begin v7 = 1'b1; v8 = 1'b1; v9 = 1'b0; oth = 1'b0; end
      default: begin v7 = 1'b1; v8 = 1'b1; v9 = 1'b1; oth = 1'b1; end
    endcase
    if (e == 7) return v7;
    if (e == 8) return v8;
    if (e == 9) return v9;
    return oth;
  endfunction

  function automatic logic maj_exp(input int b);
    case (b)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;

    // Reset with enable high and rx toggling
    rst                = 1'b1;
    bus.enable         = 1'b1;
    bus.data_sample_en = 1'b1;
    bus.prescale       = 6'd8;
    bus.rx_in          = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("reset", 0, 0, 1'b1, 1'b0);
      bus.rx_in = ~bus.rx_in;
    end

    // Prescale 8, 11 bits, bit 0 low, others high
    rst        = 1'b0;
    bus.enable = 1'b0;
    step();
    chk_all("p8_idle", 0, 0, 1'b1, 1'b0);
    bus.enable = 1'b1;
    bus.rx_in  = 1'b0;
    exp_sb     = 1'b1;
    for (int k = 1; k <= 87; k++) begin
      int e, b;
      step();
      e = k % 8;
      b = k / 8;
      if (e == 6) exp_sb = (b == 0) ? 1'b0 : 1'b1;
      chk_all("p8_run", e, b, exp_sb, (e == 6));
      bus.rx_in = (b == 0) ? 1'b0 : 1'b1;
    end

    // Majority vote at prescale 16
    bus.enable   = 1'b0;
    bus.prescale = 6'd16;
    step();
    chk_all("p16_idle", 0, 0, exp_sb, 1'b0);
    bus.enable = 1'b1;
    bus.rx_in  = rx_pat(0, 0);
    for (int k = 1; k <= 64; k++) begin
      int e, b;
      step();
      e = k % 16;
      b = k / 16;
      if (e == 10) exp_sb = maj_exp(b);
      chk_all("maj16", e, b, exp_sb, (e == 10));
      bus.rx_in = rx_pat(b, e);
    end

    // Prescale change mid-frame is ignored until enable drops
    bus.data_sample_en = 1'b0;
    bus.prescale       = 6'd8;
    bus.rx_in          = 1'b1;
    for (int k = 65; k <= 96; k++) begin
      step();
      chk_all("freeze16", k % 16, k / 16, exp_sb, 1'b0);
    end
    bus.enable = 1'b0;
    step();
    chk_all("freeze_drop", 0, 0, exp_sb, 1'b0);
    bus.enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_all("refreeze8", k % 8, k / 8, exp_sb, 1'b0);
    end

    // Illegal prescale 4 behaves as 8; bit_cnt saturates at 15
    bus.enable   = 1'b0;
    bus.prescale = 6'd4;
    step();
    chk_all("p4_idle", 0, 0, exp_sb, 1'b0);
    bus.enable         = 1'b1;
    bus.data_sample_en = 1'b1;
    bus.rx_in          = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      int e, b;
      step();
      e = k % 8;
      b = (k / 8 > 15) ? 15 : k / 8;
      if (e == 6) exp_sb = (b == 0) ? 1'b0 : 1'b1;
      chk_all("p4_sat", e, b, exp_sb, (e == 6));
      bus.rx_in = (b == 0 && e >= 3 && e <= 5) ? 1'b0 : 1'b1;
    end

    // Mid-frame reset at bit 5 / edge 3 with enable held high
    bus.enable   = 1'b0;
    bus.prescale = 6'd8;
    bus.rx_in    = 1'b0;
    step();
    chk_all("rst6_idle", 0, 0, exp_sb, 1'b0);
    bus.enable   = 1'b1;
    bus.prescale = 6'd20;
    for (int k = 1; k <= 43; k++) begin
      step();
      if (k % 8 == 6) exp_sb = 1'b0;
      chk_all("pre_rst", k % 8, k / 8, exp_sb, (k % 8 == 6));
    end
    rst = 1'b1;
    step();
    chk_all("mid_rst", 0, 0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk({"post_rst", ".edge_cnt"}, 32'(bus.edge_cnt), 32'(k % 8));
      chk({"post_rst", ".bit_cnt"}, 32'(bus.bit_cnt), 32'(k / 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_edge_bit_sampler.md
Name: uart_rx_edge_bit_sampler

Overview:
Upstream timing and sampling stage of the UART receiver. It oversamples the serial line using a prescale counter and produces the `edge_cnt` and `bit_cnt` values consumed by the RX controller FSM. It also produces a 3-sample majority-voted bit (`sampled_bit`, with a `sample_valid` strobe) for the start/parity/stop checkers and the deserializer. The stage is enabled and gated by the FSM's `enable` and `data_sample_en` outputs.

Parameters:
PRESCALE_W, 6, width of prescale input and edge counter
BIT_CNT_W, 4, width of bit counter

Ports:
clk  in  1  system clock (UART RX oversample clock)
rst  in  1  reset; synchronous, active-high
rx_in  in  1  serial line, already synchronized to clk; idle high
enable  in  1  counting enable from RX FSM; low clears counters
data_sample_en  in  1  sampling enable from RX FSM
prescale  in  PRESCALE_W  oversample ratio; legal 6..63, nominal 8/16/32
edge_cnt  out  PRESCALE_W  oversample edge index within current bit, 0..prescale_q-1
bit_cnt  out  BIT_CNT_W  bit index within frame (0 = start bit)
sampled_bit  out  1  majority-voted value of the current bit
sample_valid  out  1  one-cycle strobe: sampled_bit updated this cycle

Behaviour:
- One clock; reset is synchronous and active-high. All state updates occur on posedge clk only.
- Reset (rst=1 at posedge):
  - edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0.
  - Internal sample regs s0/s1 = 1; prescale_q = 8.
  - rst overrides enable and data_sample_en, including mid-frame.
- Prescale latch (prescale_q):
  - While enable=0, prescale_q <= prescale each cycle, so it is frozen for the whole frame.
  - If prescale < 6, load 8 instead.
  - A prescale change while enable=1 has no effect until enable drops.
- Edge/bit counter, all outputs registered:
  - enable=0: edge_cnt <= 0, bit_cnt <= 0.
  - enable=1 and edge_cnt == prescale_q-1: edge_cnt <= 0; bit_cnt <= bit_cnt+1, saturating at all-ones (15 holds).
  - enable=1 otherwise: edge_cnt <= edge_cnt+1.
  - Consequence: on the first cycle enable is seen high, the outputs show edge_cnt=0, bit_cnt=0. The first increment is visible one cycle later.
- Sampler:
  - half = prescale_q >> 1. Sample points are edge_cnt == half-1, half, half+1 (prescale 8 → 3,4,5; 16 → 7,8,9; 32 → 15,16,17).
  - Sampling is active only when data_sample_en=1 and enable=1.
  - At edge_cnt == half-1: s0 <= rx_in.
  - At edge_cnt == half: s1 <= rx_in.
  - At edge_cnt == half+1: sampled_bit <= majority(s0, s1, rx_in); sample_valid <= 1.
  - All other cycles: sample_valid <= 0; sampled_bit and s0/s1 hold.
  - data_sample_en dropping between sample points: that bit produces no strobe. Stale s0/s1 are overwritten at the next half-1 point.
  - sample_valid therefore asserts for one cycle with edge_cnt == half+2 (modulo wrap) visible at the same time.
- Boundaries:
  - enable deasserted mid-bit: counters clear next cycle; sampled_bit holds its last value; no strobe.
  - enable re-asserted in the cycle after deassert: restart from edge_cnt=0.
  - bit_cnt saturates, never wraps; the FSM relies on values 0..10 only.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset: rst=1 for 2 cycles with enable=1 and rx_in toggling → edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0 throughout.
2. prescale=8, enable=1 for 88 cycles → edge_cnt cycles 0..7. bit_cnt steps 0→10 at each edge_cnt 7→0 wrap. With data_sample_en=1, rx_in=0 on bit 0 and 1 after → sample_valid pulses with edge_cnt=6; sampled_bit=0 for bit 0 and 1 for bits 1..10.
3. Majority vote: prescale=16, rx_in = 1,0,0 at edges 7,8,9 → sampled_bit=0. Then 0,1,1 → sampled_bit=1. Each gives one strobe, with edge_cnt=10 visible.
4. Prescale freeze: prescale=16 latched at enable rise; drive prescale=8 mid-frame → wrap still at edge_cnt 15. Drop enable for 1 cycle, re-enable → wrap at 7.
5. Illegal prescale=4 → behaves as 8 (wrap at 7, samples at 3,4,5). Enable=1 for 300 cycles → bit_cnt saturates at 15.
6. Reset mid-frame at bit_cnt=5, edge_cnt=3 with enable held high → next cycle counters=0 and sampled_bit=1. After rst releases, counting restarts with edge_cnt=0 in the first cycle.
